// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port 16-bit RAM between two masters.
// Grants are combinational from the current requests plus the registered
// arbitration history. Read data and range errors come back one cycle after
// the grant on the owning master's response signals.
module ram_arbiter #(
    parameter int ADDR_MSB   = 6,
    parameter int MEM_SIZE   = 256,
    parameter int PRIO_MODE  = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic                mclk,
    input  logic                reset_n,

    input  logic                m0_req,
    input  logic [ADDR_MSB:0]   m0_addr,
    input  logic [15:0]         m0_din,
    input  logic [1:0]          m0_wen,
    output logic                m0_gnt,
    output logic                m0_rdv,
    output logic [15:0]         m0_dout,
    output logic                m0_err,

    input  logic                m1_req,
    input  logic [ADDR_MSB:0]   m1_addr,
    input  logic [15:0]         m1_din,
    input  logic [1:0]          m1_wen,
    output logic                m1_gnt,
    output logic                m1_rdv,
    output logic [15:0]         m1_dout,
    output logic                m1_err,

    output logic [ADDR_MSB:0]   ram_addr,
    output logic                ram_cen,
    output logic [15:0]         ram_din,
    output logic [1:0]          ram_wen,
    input  logic [15:0]         ram_dout
);

    // Number of valid word addresses; anything at or above this is out of range.
    localparam logic [31:0] WORD_COUNT   = 32'(MEM_SIZE / 2);
    localparam logic [3:0]  STARVE_LIMIT = 4'(STARVE_MAX);

    // Which master received the most recent grant.
    typedef enum logic {
        LAST_M0 = 1'b0,
        LAST_M1 = 1'b1
    } last_t;

    last_t             last_gnt;
    last_t             last_gnt_next;
    logic [3:0]        starve_cnt;
    logic [3:0]        starve_cnt_next;

    logic              m1_wins;
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              in_range;
    logic [ADDR_MSB:0] sel_addr;

    logic              rdv0_q;
    logic              rdv1_q;
    logic              err0_q;
    logic              err1_q;

    // Pick the owner of the RAM this cycle; no grants at all while in reset.
    always_comb begin
        m1_wins = m1_req;
        if (m0_req && m1_req) begin
            if (PRIO_MODE == 0) begin
                m1_wins = (starve_cnt == STARVE_LIMIT);
            end else begin
                m1_wins = (last_gnt == LAST_M0);
            end
        end
        gnt0    = reset_n & m0_req & ~m1_wins;
        gnt1    = reset_n & m1_req & m1_wins;
        any_gnt = gnt0 | gnt1;
    end

    // Steer the winner's request to the RAM, defaulting to m0 when idle.
    always_comb begin
        sel_addr = gnt1 ? m1_addr : m0_addr;
        in_range = (32'(sel_addr) < WORD_COUNT);
        ram_addr = sel_addr;
        ram_din  = gnt1 ? m1_din : m0_din;
        ram_wen  = gnt1 ? m1_wen : m0_wen;
        ram_cen  = ~(any_gnt & in_range);
    end

    // Work out the next arbitration history from this cycle's outcome.
    always_comb begin
        last_gnt_next   = last_gnt;
        starve_cnt_next = starve_cnt;
        if (gnt0) begin
            last_gnt_next = LAST_M0;
        end else if (gnt1) begin
            last_gnt_next = LAST_M1;
        end
        if (!m1_req || gnt1) begin
            starve_cnt_next = 4'd0;
        end else if (gnt0 && (starve_cnt != STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt + 4'd1;
        end
    end

    // Arbitration history register; after reset m0 wins the first contention.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt   <= LAST_M1;
            starve_cnt <= 4'd0;
        end else begin
            last_gnt   <= last_gnt_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // One-cycle response flags for the access granted on the previous cycle.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            rdv0_q <= 1'b0;
            rdv1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            rdv0_q <= gnt0 & in_range & (m0_wen == 2'b11);
            rdv1_q <= gnt1 & in_range & (m1_wen == 2'b11);
            err0_q <= gnt0 & ~in_range;
            err1_q <= gnt1 & ~in_range;
        end
    end

    assign m0_gnt  = gnt0;
    assign m1_gnt  = gnt1;
    assign m0_rdv  = rdv0_q;
    assign m1_rdv  = rdv1_q;
    assign m0_err  = err0_q;
    assign m1_err  = err1_q;
    assign m0_dout = rdv0_q ? ram_dout : 16'h0000;
    assign m1_dout = rdv1_q ? ram_dout : 16'h0000;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: drives a fixed-priority and a round-robin arbiter with the
// same master traffic, each in front of its own behavioural RAM, and compares
// both against a reference model of the arbitration and memory rules.
module tb_ram_arbiter;

    localparam int WORDS = 64;
    localparam int SMAX  = 4;

    typedef struct {
        logic        req0;
        logic [6:0]  addr0;
        logic [1:0]  wen0;
        logic [15:0] din0;
        logic        req1;
        logic [6:0]  addr1;
        logic [1:0]  wen1;
        logic [15:0] din1;
        logic [1:0]  exp_fix;
        logic [1:0]  exp_rr;
    } vec_t;

    logic        mclk = 1'b0;
    logic        reset_n = 1'b1;
    logic        m0_req, m1_req;
    logic [6:0]  m0_addr, m1_addr;
    logic [15:0] m0_din, m1_din;
    logic [1:0]  m0_wen, m1_wen;

    // Index 0 is the fixed-priority instance, index 1 the round-robin one.
    logic [1:0]  g0_v, g1_v, rdv0_v, rdv1_v, err0_v, err1_v, cen_v;
    logic [31:0] dout0_v, dout1_v, rdin_v;
    logic [13:0] raddr_v;
    logic [3:0]  rwen_v;
    logic [15:0] rdout_f, rdout_r;
    logic [15:0] mem_f [128];
    logic [15:0] mem_r [128];

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] ref_mem [2][128];
    bit          exp_rdv [2][2];
    bit          exp_err [2][2];
    logic [15:0] exp_dat [2][2];
    int          streak;
    bit          last_m1;

    vec_t tbl [21];

    always #5 mclk = ~mclk;

    ram_arbiter #(.ADDR_MSB(6), .MEM_SIZE(128), .PRIO_MODE(0), .STARVE_MAX(SMAX)) dut_fix (
        .mclk(mclk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din), .m0_wen(m0_wen),
        .m0_gnt(g0_v[0]), .m0_rdv(rdv0_v[0]), .m0_dout(dout0_v[15:0]), .m0_err(err0_v[0]),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din), .m1_wen(m1_wen),
        .m1_gnt(g1_v[0]), .m1_rdv(rdv1_v[0]), .m1_dout(dout1_v[15:0]), .m1_err(err1_v[0]),
        .ram_addr(raddr_v[6:0]), .ram_cen(cen_v[0]), .ram_din(rdin_v[15:0]),
        .ram_wen(rwen_v[1:0]), .ram_dout(rdout_f)
    );

    ram_arbiter #(.ADDR_MSB(6), .MEM_SIZE(128), .PRIO_MODE(1), .STARVE_MAX(SMAX)) dut_rr (
        .mclk(mclk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din), .m0_wen(m0_wen),
        .m0_gnt(g0_v[1]), .m0_rdv(rdv0_v[1]), .m0_dout(dout0_v[31:16]), .m0_err(err0_v[1]),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din), .m1_wen(m1_wen),
        .m1_gnt(g1_v[1]), .m1_rdv(rdv1_v[1]), .m1_dout(dout1_v[31:16]), .m1_err(err1_v[1]),
        .ram_addr(raddr_v[13:7]), .ram_cen(cen_v[1]), .ram_din(rdin_v[31:16]),
        .ram_wen(rwen_v[3:2]), .ram_dout(rdout_r)
    );

    // Behavioural RAM behind the fixed-priority arbiter; wiped while in reset.
    always @(posedge mclk) begin
        if (!reset_n) begin
            for (int i = 0; i < 128; i++) mem_f[i] <= 16'hFFFF;
        end else if (!cen_v[0]) begin
            if (rwen_v[1:0] == 2'b11) begin
                rdout_f <= mem_f[raddr_v[6:0]];
            end else begin
                if (!rwen_v[0]) mem_f[raddr_v[6:0]][7:0]  <= rdin_v[7:0];
                if (!rwen_v[1]) mem_f[raddr_v[6:0]][15:8] <= rdin_v[15:8];
            end
        end
    end

    // Behavioural RAM behind the round-robin arbiter; wiped while in reset.
    always @(posedge mclk) begin
        if (!reset_n) begin
            for (int i = 0; i < 128; i++) mem_r[i] <= 16'hFFFF;
        end else if (!cen_v[1]) begin
            if (rwen_v[3:2] == 2'b11) begin
                rdout_r <= mem_r[raddr_v[13:7]];
            end else begin
                if (!rwen_v[2]) mem_r[raddr_v[13:7]][7:0]  <= rdin_v[23:16];
                if (!rwen_v[3]) mem_r[raddr_v[13:7]][15:8] <= rdin_v[31:24];
            end
        end
    end

    function automatic vec_t mk(input logic r0, input logic [6:0] a0, input logic [1:0] w0,
                                input logic [15:0] d0, input logic r1, input logic [6:0] a1,
                                input logic [1:0] w1, input logic [15:0] d1,
                                input logic [1:0] ef, input logic [1:0] er);
        vec_t v;
        v.req0 = r0; v.addr0 = a0; v.wen0 = w0; v.din0 = d0;
        v.req1 = r1; v.addr1 = a1; v.wen1 = w1; v.din1 = d1;
        v.exp_fix = ef; v.exp_rr = er;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Response signals produced by the previous cycle's grant, for both instances.
    task automatic checkRegistered();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rdv0_d%0d", d), 32'(rdv0_v[d]), 32'(exp_rdv[d][0]));
            checkOutput($sformatf("rdv1_d%0d", d), 32'(rdv1_v[d]), 32'(exp_rdv[d][1]));
            checkOutput($sformatf("err0_d%0d", d), 32'(err0_v[d]), 32'(exp_err[d][0]));
            checkOutput($sformatf("err1_d%0d", d), 32'(err1_v[d]), 32'(exp_err[d][1]));
            checkOutput($sformatf("dout0_d%0d", d), 32'(dout0_v[d*16 +: 16]),
                        exp_rdv[d][0] ? 32'(exp_dat[d][0]) : 32'h0);
            checkOutput($sformatf("dout1_d%0d", d), 32'(dout1_v[d*16 +: 16]),
                        exp_rdv[d][1] ? 32'(exp_dat[d][1]) : 32'h0);
        end
    endtask

    // Reference model: who should win, what the RAM should see, what comes back.
    task automatic modelCycle(input int d, input vec_t v);
        bit          w1, granted, inr;
        logic [6:0]  a;
        logic [1:0]  w;
        logic [15:0] din;
        granted = v.req0 || v.req1;
        if (v.req0 && v.req1) w1 = (d == 0) ? (streak == SMAX) : !last_m1;
        else                  w1 = v.req1;
        a   = w1 ? v.addr1 : v.addr0;
        w   = w1 ? v.wen1  : v.wen0;
        din = w1 ? v.din1  : v.din0;
        inr = (int'(a) < WORDS);
        checkOutput($sformatf("gnt0_d%0d", d), 32'(g0_v[d]), 32'(granted && !w1));
        checkOutput($sformatf("gnt1_d%0d", d), 32'(g1_v[d]), 32'(granted && w1));
        checkOutput($sformatf("cen_d%0d", d), 32'(cen_v[d]), 32'(!(granted && inr)));
        checkOutput($sformatf("raddr_d%0d", d), 32'(raddr_v[d*7 +: 7]), 32'(a));
        checkOutput($sformatf("rwen_d%0d", d), 32'(rwen_v[d*2 +: 2]), 32'(w));
        checkOutput($sformatf("rdin_d%0d", d), 32'(rdin_v[d*16 +: 16]), 32'(din));
        for (int m = 0; m < 2; m++) begin
            exp_rdv[d][m] = granted && (w1 == (m == 1)) && inr && (w == 2'b11);
            exp_err[d][m] = granted && (w1 == (m == 1)) && !inr;
            exp_dat[d][m] = ref_mem[d][a];
        end
        if (granted && inr && w != 2'b11) begin
            if (!w[0]) ref_mem[d][a][7:0]  = din[7:0];
            if (!w[1]) ref_mem[d][a][15:8] = din[15:8];
        end
        if (d == 0) begin
            if (v.req1 && granted && !w1) streak = (streak < SMAX) ? streak + 1 : SMAX;
            else                          streak = 0;
        end else if (granted) begin
            last_m1 = w1;
        end
    endtask

    // Drive one cycle of master traffic at the falling edge and check both instances.
    task automatic applyStimulus(input vec_t v);
        @(negedge mclk);
        m0_req = v.req0; m0_addr = v.addr0; m0_wen = v.wen0; m0_din = v.din0;
        m1_req = v.req1; m1_addr = v.addr1; m1_wen = v.wen1; m1_din = v.din1;
        #1;
        checkRegistered();
        modelCycle(0, v);
        modelCycle(1, v);
    endtask

    task automatic checkResetState(input string tag);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s_gnt_d%0d", tag, d), 32'({g1_v[d], g0_v[d]}), 32'h0);
            checkOutput($sformatf("%s_cen_d%0d", tag, d), 32'(cen_v[d]), 32'h1);
            checkOutput($sformatf("%s_rdv_d%0d", tag, d), 32'({rdv1_v[d], rdv0_v[d]}), 32'h0);
            checkOutput($sformatf("%s_err_d%0d", tag, d), 32'({err1_v[d], err0_v[d]}), 32'h0);
            checkOutput($sformatf("%s_dout_d%0d", tag, d),
                        {dout1_v[d*16 +: 16], dout0_v[d*16 +: 16]}, 32'h0);
        end
    endtask

    // Assert reset with both masters requesting, hold across clock edges, release at a falling edge.
    task automatic resetPulse();
        reset_n = 1'b0;
        m0_req = 1'b1; m0_addr = 7'h01; m0_wen = 2'b11;
        m1_req = 1'b1; m1_addr = 7'h02; m1_wen = 2'b11;
        #1;
        checkResetState("rst_async");
        @(negedge mclk);
        #1;
        checkResetState("rst_held");
        @(negedge mclk);
        m0_req = 1'b0;
        m1_req = 1'b0;
        reset_n = 1'b1;
        streak  = 0;
        last_m1 = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                exp_rdv[d][m] = 1'b0;
                exp_err[d][m] = 1'b0;
                exp_dat[d][m] = 16'h0;
            end
            for (int i = 0; i < 128; i++) ref_mem[d][i] = 16'hFFFF;
        end
    endtask

    initial begin
        vec_t v;
        m0_req = 1'b0; m0_addr = '0; m0_din = '0; m0_wen = 2'b11;
        m1_req = 1'b0; m1_addr = '0; m1_din = '0; m1_wen = 2'b11;

        // {req0,addr0,wen0,din0, req1,addr1,wen1,din1, {g1,g0} fixed, {g1,g0} round-robin}
        tbl[0]  = mk(1, 7'h05, 2'b00, 16'hA5A5, 0, 7'h00, 2'b11, 16'h0000, 2'b01, 2'b01);
        tbl[1]  = mk(0, 7'h00, 2'b11, 16'h0000, 1, 7'h06, 2'b00, 16'h5A5A, 2'b10, 2'b10);
        tbl[2]  = mk(1, 7'h05, 2'b11, 16'h0000, 1, 7'h06, 2'b11, 16'h0000, 2'b01, 2'b01);
        tbl[3]  = mk(1, 7'h05, 2'b11, 16'h0000, 1, 7'h06, 2'b11, 16'h0000, 2'b01, 2'b10);
        tbl[4]  = mk(1, 7'h05, 2'b11, 16'h0000, 1, 7'h06, 2'b11, 16'h0000, 2'b01, 2'b01);
        tbl[5]  = mk(1, 7'h05, 2'b11, 16'h0000, 1, 7'h06, 2'b11, 16'h0000, 2'b01, 2'b10);
        tbl[6]  = mk(1, 7'h05, 2'b11, 16'h0000, 1, 7'h06, 2'b11, 16'h0000, 2'b10, 2'b01);
        tbl[7]  = mk(1, 7'h05, 2'b11, 16'h0000, 1, 7'h06, 2'b11, 16'h0000, 2'b01, 2'b10);
        tbl[8]  = mk(1, 7'h05, 2'b11, 16'h0000, 1, 7'h06, 2'b11, 16'h0000, 2'b01, 2'b01);
        tbl[9]  = mk(1, 7'h05, 2'b11, 16'h0000, 1, 7'h06, 2'b11, 16'h0000, 2'b01, 2'b10);
        tbl[10] = mk(1, 7'h05, 2'b11, 16'h0000, 1, 7'h06, 2'b11, 16'h0000, 2'b01, 2'b01);
        tbl[11] = mk(1, 7'h05, 2'b11, 16'h0000, 1, 7'h06, 2'b11, 16'h0000, 2'b10, 2'b10);
        tbl[12] = mk(1, 7'h20, 2'b10, 16'h1234, 0, 7'h00, 2'b11, 16'h0000, 2'b01, 2'b01);
        tbl[13] = mk(1, 7'h20, 2'b11, 16'h0000, 0, 7'h00, 2'b11, 16'h0000, 2'b01, 2'b01);
        tbl[14] = mk(0, 7'h00, 2'b11, 16'h0000, 1, 7'h05, 2'b11, 16'h0000, 2'b10, 2'b10);
        tbl[15] = mk(1, 7'h40, 2'b00, 16'hBEEF, 0, 7'h00, 2'b11, 16'h0000, 2'b01, 2'b01);
        tbl[16] = mk(1, 7'h40, 2'b11, 16'h0000, 0, 7'h00, 2'b11, 16'h0000, 2'b01, 2'b01);
        tbl[17] = mk(1, 7'h3F, 2'b11, 16'h0000, 1, 7'h41, 2'b00, 16'hCAFE, 2'b01, 2'b10);
        tbl[18] = mk(0, 7'h00, 2'b11, 16'h0000, 0, 7'h00, 2'b11, 16'h0000, 2'b00, 2'b00);
        tbl[19] = mk(0, 7'h33, 2'b01, 16'h1111, 0, 7'h44, 2'b10, 16'h2222, 2'b00, 2'b00);
        tbl[20] = mk(1, 7'h20, 2'b11, 16'h0000, 1, 7'h20, 2'b11, 16'h0000, 2'b01, 2'b01);

        #2;
        $display("[TB] power-on reset");
        resetPulse();

        $display("[TB] table vectors");
        for (int i = 0; i < 21; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("tbl%0d_gnt_fix", i), 32'({g1_v[0], g0_v[0]}), 32'(tbl[i].exp_fix));
            checkOutput($sformatf("tbl%0d_gnt_rr", i), 32'({g1_v[1], g0_v[1]}), 32'(tbl[i].exp_rr));
        end

        $display("[TB] partial write then read back by m1");
        applyStimulus(mk(0, 7'h00, 2'b11, 16'h0000, 1, 7'h10, 2'b01, 16'h1234, 2'b00, 2'b00));
        applyStimulus(mk(0, 7'h00, 2'b11, 16'h0000, 1, 7'h10, 2'b11, 16'h0000, 2'b00, 2'b00));
        applyStimulus(mk(0, 7'h00, 2'b11, 16'h0000, 0, 7'h00, 2'b11, 16'h0000, 2'b00, 2'b00));
        checkOutput("pw_rdv1", 32'(rdv1_v), 32'h3);
        checkOutput("pw_dout1_fix", 32'(dout1_v[15:0]), 32'h12FF);
        checkOutput("pw_dout1_rr", 32'(dout1_v[31:16]), 32'h12FF);
        applyStimulus(mk(0, 7'h00, 2'b11, 16'h0000, 0, 7'h00, 2'b11, 16'h0000, 2'b00, 2'b00));
        checkOutput("pw_rdv1_once", 32'(rdv1_v), 32'h0);

        $display("[TB] out-of-range read by m0");
        applyStimulus(mk(1, 7'h7F, 2'b11, 16'h0000, 0, 7'h00, 2'b11, 16'h0000, 2'b00, 2'b00));
        checkOutput("oor_gnt0", 32'(g0_v), 32'h3);
        checkOutput("oor_cen", 32'(cen_v), 32'h3);
        applyStimulus(mk(0, 7'h00, 2'b11, 16'h0000, 0, 7'h00, 2'b11, 16'h0000, 2'b00, 2'b00));
        checkOutput("oor_err0", 32'(err0_v), 32'h3);
        checkOutput("oor_rdv0", 32'(rdv0_v), 32'h0);
        applyStimulus(mk(0, 7'h00, 2'b11, 16'h0000, 0, 7'h00, 2'b11, 16'h0000, 2'b00, 2'b00));
        checkOutput("oor_err0_pulse", 32'(err0_v), 32'h0);

        $display("[TB] reset right after a granted read");
        applyStimulus(mk(1, 7'h05, 2'b11, 16'h0000, 0, 7'h00, 2'b11, 16'h0000, 2'b00, 2'b00));
        @(posedge mclk);
        #1;
        checkOutput("pre_rst_rdv0", 32'(rdv0_v), 32'h3);
        resetPulse();
        applyStimulus(mk(1, 7'h05, 2'b11, 16'h0000, 1, 7'h06, 2'b11, 16'h0000, 2'b00, 2'b00));
        checkOutput("post_rst_rr_gnt", 32'({g1_v[1], g0_v[1]}), 32'h1);
        checkOutput("post_rst_fix_gnt", 32'({g1_v[0], g0_v[0]}), 32'h1);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            v.req0  = ($urandom_range(0, 3) != 0);
            v.req1  = ($urandom_range(0, 3) != 0);
            v.addr0 = 7'($urandom_range(0, 127));
            v.addr1 = 7'($urandom_range(0, 127));
            v.wen0  = 2'($urandom_range(0, 3));
            v.wen1  = 2'($urandom_range(0, 3));
            v.din0  = 16'($urandom);
            v.din1  = 16'($urandom);
            v.exp_fix = 2'b00;
            v.exp_rr  = 2'b00;
            applyStimulus(v);
        end
        applyStimulus(mk(0, 7'h00, 2'b11, 16'h0000, 0, 7'h00, 2'b11, 16'h0000, 2'b00, 2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_MSB, default 6: MSB of the word address bus.
REQ-002 Parameter MEM_SIZE, default 256: RAM size in bytes; valid word addresses are 0..MEM_SIZE/2-1.
REQ-003 Parameter PRIO_MODE, default 0: 0 selects fixed priority (m0 high), 1 selects round-robin.
REQ-004 Parameter STARVE_MAX, default 4, range 1..15: maximum consecutive contested m0 grants in fixed mode.
REQ-005 mclk  input  1  single clock; all flops are on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 mX_req  input  1  access request from master X (X = 0, 1).
REQ-008 mX_addr  input  ADDR_MSB+1  word address from master X.
REQ-009 mX_din  input  16  write data from master X.
REQ-010 mX_wen  input  2  byte write enables, low active; 2'b11 means read.
REQ-011 mX_gnt  output  1  access accepted this cycle.
REQ-012 mX_rdv  output  1  read data valid, one cycle after a granted in-range read.
REQ-013 mX_dout  output  16  read data, qualified by mX_rdv.
REQ-014 mX_err  output  1  one-cycle pulse flagging an out-of-range access.
REQ-015 ram_addr  output  ADDR_MSB+1  RAM word address.
REQ-016 ram_cen  output  1  RAM chip enable, low active.
REQ-017 ram_din  output  16  RAM write data.
REQ-018 ram_wen  output  2  RAM byte write enables, low active.
REQ-019 ram_dout  input  16  RAM read data, valid the cycle after the address is sampled.

Function
REQ-020 Grant is combinational from the current requests and registered arbiter state; at most one mX_gnt is high per cycle.
REQ-021 A request held low produces no grant; a request is accepted in the cycle mX_gnt is high, and each grant cycle is one access.
REQ-022 Uncontested request: grant the requester in the same cycle.
REQ-023 Contested, PRIO_MODE=0: grant m0 unless starve_cnt equals STARVE_MAX, in which case grant m1.
REQ-024 starve_cnt (4 bits):
- increments on each m0 grant while m1_req is high;
- clears on any m1 grant or any cycle with m1_req low;
- saturates at STARVE_MAX.
REQ-025 Contested, PRIO_MODE=1: grant the master that is not last_gnt.
REQ-026 last_gnt updates to the granted master on every grant and holds otherwise.
REQ-027 RAM port muxing: ram_addr, ram_din and ram_wen take the granted master's signals; with no grant they take m0's signals.
REQ-028 ram_cen is low only when a grant is high and the granted address is below MEM_SIZE/2.
REQ-029 A granted out-of-range access keeps ram_cen high; it performs no write and no rdv, and pulses mX_err in the following cycle.
REQ-030 A granted in-range read (wen = 2'b11) asserts mX_rdv for exactly one cycle, the cycle after the grant.
REQ-031 Granted writes produce no rdv and no err.
REQ-032 mX_dout equals ram_dout while mX_rdv is high and 16'h0000 otherwise.
REQ-033 Back-to-back reads by alternating masters return each master's data in its own rdv cycle, with no bubble.
REQ-034 Partial writes (wen 2'b01 or 2'b10) pass through unchanged; the read-modify-write is done by the RAM.

Reset
REQ-035 On reset_n low, asynchronously:
- last_gnt = m1, so m0 wins the first round-robin contention;
- starve_cnt = 0;
- all mX_rdv and mX_err = 0.
REQ-036 During reset:
- ram_cen = 1 and all mX_gnt = 0, regardless of requests;
- mX_dout = 0.
REQ-037 A read granted in the cycle before reset asserts yields no rdv after reset; release is synchronous to the next mclk edge.

Verification
REQ-038 Fixed mode, STARVE_MAX=4, both masters requesting continuously -> grant pattern m0,m0,m0,m0,m1 repeating; ram_cen low every cycle.
REQ-039 Round-robin, both requesting reads from 0x05 and 0x06 (preloaded 16'hA5A5/16'h5A5A) -> gnt alternates m0,m1,...; m0_rdv with 16'hA5A5 and m1_rdv with 16'h5A5A in alternating cycles.
REQ-040 m1 alone writes 16'h1234 to 0x10 with wen=2'b01, then reads 0x10 (old 16'hFFFF) -> read returns 16'h12FF; m1_rdv high exactly one cycle.
REQ-041 m0 reads address 0x7F with MEM_SIZE=128 -> m0_gnt=1, ram_cen stays 1, m0_err pulses next cycle, m0_rdv stays 0.
REQ-042 reset_n pulsed low in the cycle after a granted read -> rdv suppressed, gnt=0 and ram_cen=1 during reset; first contention after release goes to m0 in round-robin mode.
